// File: rtl/bridge_timer.sv
// Memory-mapped countdown timer on the CPU bridge bus (CTRL/PRESET/COUNT), one-shot or periodic, irq to CP0.
// Zero wait states: writes land on the strobed edge; rd is a combinational read mux.
module bridge_timer #(
  parameter logic [31:0] BASE = 32'h00007f00
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t      state_q;
  logic [3:0]  ctrl_q;     // {IM, MODE[1:0], EN}
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_flag_q;

  logic [31:0] off;
  logic        hit;
  logic [1:0]  sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        periodic;
  logic        en_load;

  // Addresses below BASE wrap to a huge offset, so one compare covers both bounds.
  assign off       = addr - BASE;
  assign hit       = (off <= 32'hB);
  assign sel       = off[3:2];
  assign wr_ctrl   = we && hit && (sel == 2'd0);
  assign wr_preset = we && hit && (sel == 2'd1);
  assign periodic  = (ctrl_q[2:1] == 2'b01);
  assign en_load   = wr_ctrl ? wd[0] : ctrl_q[0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= S_IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ctrl_q[0]) state_q <= S_LOAD;
        end
        S_LOAD: begin
          count_q <= preset_q;
          state_q <= en_load ? S_CNT : S_IDLE;
        end
        S_CNT: begin
          if (!ctrl_q[0]) begin
            state_q <= S_IDLE;
          end else if (count_q == 32'd0) begin
            state_q <= S_INT;
          end else if (count_q == 32'd1) begin
            count_q <= 32'd0;
            state_q <= S_INT;
          end else begin
            count_q <= count_q - 32'd1;
          end
        end
        default: begin
          if (periodic) begin
            state_q <= S_LOAD;
          end else begin
            ctrl_q[0] <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
      endcase

      // A CTRL write in the INT cycle overrides both the flag set and the EN auto-clear.
      if (state_q == S_INT)             irq_flag_q <= !wr_ctrl;
      else if (wr_ctrl || wr_preset)    irq_flag_q <= 1'b0;
      else if (periodic)                irq_flag_q <= 1'b0;

      if (wr_ctrl)   ctrl_q   <= wd[3:0];
      if (wr_preset) preset_q <= wd;
    end
  end

  always_comb begin
    rd = 32'd0;
    if (hit) begin
      case (sel)
        2'd0:    rd = {28'd0, ctrl_q};
        2'd1:    rd = preset_q;
        2'd2:    rd = count_q;
        default: rd = 32'd0;
      endcase
    end
  end

  assign irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_bridge_timer.sv
// Randomised and directed bus traffic against a behavioural timer model; a negedge monitor scores rd and irq.
module tb_bridge_timer;

  localparam logic [31:0] BASE = 32'h00007f00;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CNT = 2, PH_INT = 3;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        irq;

  bridge_timer #(.BASE(BASE)) dut (
    .clk(clk), .clr(clr), .we(we), .addr(addr), .wd(wd), .rd(rd), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model of the programmer-visible timer.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  int          m_phase;

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'hB);
  endfunction

  function automatic int reg_index(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!in_window(a)) return 32'd0;
    case (reg_index(a))
      0:       return {28'd0, m_ctrl};
      1:       return m_preset;
      2:       return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0; m_phase = PH_IDLE;
  endtask

  // Advance the model by one clock edge using the bus inputs that were present at that edge.
  task automatic model_edge();
    bit          w_ctrl, w_pre, en, per;
    logic [3:0]  n_ctrl;
    logic [31:0] n_count;
    logic        n_flag;
    int          n_phase;
    w_ctrl  = we && in_window(addr) && reg_index(addr) == 0;
    w_pre   = we && in_window(addr) && reg_index(addr) == 1;
    en      = m_ctrl[0];
    per     = (m_ctrl[2:1] == 2'b01);
    n_ctrl  = m_ctrl;
    n_count = m_count;
    n_flag  = m_flag;
    n_phase = m_phase;
    if (m_phase == PH_IDLE) begin
      if (en) n_phase = PH_LOAD;
    end else if (m_phase == PH_LOAD) begin
      n_count = m_preset;
      n_phase = (w_ctrl ? wd[0] : en) ? PH_CNT : PH_IDLE;
    end else if (m_phase == PH_CNT) begin
      if (!en) n_phase = PH_IDLE;
      else if (m_count <= 32'd1) begin n_count = 32'd0; n_phase = PH_INT; end
      else n_count = m_count - 32'd1;
    end else begin
      n_phase = per ? PH_LOAD : PH_IDLE;
      if (!per) n_ctrl[0] = 1'b0;
    end
    if (m_phase == PH_INT) n_flag = !w_ctrl;
    else if (w_ctrl || w_pre || per) n_flag = 1'b0;
    if (w_ctrl) n_ctrl = wd[3:0];
    if (w_pre) m_preset = wd;
    m_ctrl = n_ctrl; m_count = n_count; m_flag = n_flag; m_phase = n_phase;
  endtask

  task automatic expect_now();
    exp_q.push_back('{addr, m_read(addr), m_flag & m_ctrl[3]});
  endtask

  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    if (clr) model_edge();
    we = w; addr = a; wd = d;
    expect_now();
  endtask

  task automatic reads(input int n, input logic [31:0] a);
    for (int i = 0; i < n; i++) cyc(1'b0, a, 32'd0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors += 2;
      if (rd !== e.rd) begin
        miscompares++;
        $display("FAIL rd @%h: got %h expected %h (t=%0t)", e.a, rd, e.rd, $time);
      end
      if (irq !== e.irq) begin
        miscompares++;
        $display("FAIL irq @%h: got %b expected %b (t=%0t)", e.a, irq, e.irq, $time);
      end
    end
  end

  initial begin
    model_reset();
    // Reset state across the whole window and just outside it.
    cyc(1'b0, BASE, 0); cyc(1'b0, BASE + 4, 0); cyc(1'b0, BASE + 8, 0); cyc(1'b0, BASE + 12, 0);
    @(posedge clk); #1; clr = 1'b1;
    reads(2, BASE);

    // One-shot with IM, then clear by CTRL write.
    cyc(1'b1, BASE + 4, 32'd5);
    cyc(1'b1, BASE, 32'h9);
    reads(12, BASE + 8);
    reads(2, BASE);
    cyc(1'b1, BASE, 32'h8);
    reads(3, BASE);

    // Periodic PRESET=3.
    cyc(1'b1, BASE + 4, 32'd3);
    cyc(1'b1, BASE, 32'hB);
    reads(25, BASE + 8);
    cyc(1'b1, BASE, 32'h0);
    reads(3, BASE + 8);

    // Masked one-shot.
    cyc(1'b1, BASE + 4, 32'd5);
    cyc(1'b1, BASE, 32'h1);
    reads(12, BASE);
    cyc(1'b1, BASE, 32'h8);
    reads(3, BASE);

    // CTRL=3 written in the INT cycle of a PRESET=2 one-shot.
    cyc(1'b1, BASE + 4, 32'd2);
    cyc(1'b1, BASE, 32'h1);
    reads(4, BASE + 8);
    cyc(1'b1, BASE, 32'h3);
    reads(12, BASE + 8);
    cyc(1'b1, BASE, 32'h0);

    // PRESET rewritten mid-count; COUNT write ignored; window-edge writes ignored.
    cyc(1'b1, BASE + 4, 32'd4);
    cyc(1'b1, BASE, 32'hB);
    reads(3, BASE + 8);
    cyc(1'b1, BASE + 4, 32'd100);
    reads(10, BASE + 8);
    cyc(1'b1, BASE + 8, 32'h55);
    reads(2, BASE + 8);
    cyc(1'b1, BASE, 32'h0);
    cyc(1'b1, BASE + 12, 32'hFFFF_FFFF);
    cyc(1'b1, BASE - 4, 32'hFFFF_FFFF);
    cyc(1'b1, BASE + 7, 32'd9);
    reads(1, BASE + 5);
    reads(1, BASE + 3);

    // EN cleared during LOAD.
    cyc(1'b1, BASE, 32'h1);
    reads(1, BASE + 8);
    cyc(1'b1, BASE, 32'h0);
    reads(4, BASE + 8);

    // Asynchronous reset mid-count, then idle until EN is written.
    cyc(1'b1, BASE + 4, 32'd20);
    cyc(1'b1, BASE, 32'hF);
    reads(15, BASE + 8);
    @(posedge clk); #1;
    model_edge();
    clr = 1'b0; model_reset();
    we = 1'b0; addr = BASE + 8;
    expect_now();
    cyc(1'b0, BASE, 0);
    @(posedge clk); #1; clr = 1'b1;
    reads(10, BASE + 8);
    reads(1, BASE);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        w;
      logic [31:0] a, d;
      int          pick;
      w    = ($urandom_range(0, 7) == 0);
      pick = $urandom_range(0, 9);
      if (pick < 8) a = BASE + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      else if (pick == 8) a = BASE - 32'($urandom_range(1, 8));
      else a = $urandom;
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 8));
      cyc(w, a, d);
    end

    @(posedge clk); #1; we = 1'b0;
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
